pwl_activation: RTL
===================

# pwl_activation

Pipelined, multi-lane piecewise-linear activation unit for the GRU datapath. It computes either sigmoid or tanh on LANES signed fixed-point operands per transaction. Both use the same 7-region sigmoid approximation; tanh is derived as 2·σ(2x) − 1. It replaces the single-lane combinational sigmoid in the gate pipeline and adds a valid/ready handshake, registered stages and a per-transaction mode select.

## Interface
Parameters:
- INT_WIDTH, 8, integer bits of Q format
- FRAC_WIDTH, 8, fractional bits of Q format
- WIDTH, INT_WIDTH+FRAC_WIDTH+1, signed operand width
- LANES, 4, operands processed per transaction

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept input this cycle
- in_mode  in  1  0 = sigmoid, 1 = tanh
- in_x  in  LANES*WIDTH  packed signed operands; lane i at [i*WIDTH +: WIDTH]
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts output
- out_mode  out  1  mode carried with the transaction
- out_y  out  LANES*WIDTH  packed signed results, same Q format
- busy  out  1  any pipeline stage holds a valid transaction

## Operation
- Constants are built as round-toward-zero of value·2^FRAC_WIDTH.
- Stage 0 (argument prep):
  - Sigmoid: u = x.
  - Tanh: u = 2x, saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Region select on u, in priority order:
    - u ≤ −5 → R0
    - u ≤ −2.375 → R1
    - u ≤ −1 → R2
    - u ≤ 1 → R3
    - u ≤ 2.375 → R4
    - u ≤ 5 → R5
    - otherwise → R6
  - Register u, region and mode.
- Stage 1 (multiply): p = u · slope, at 2·WIDTH bits signed.
  - Slopes: R1 and R5 use 0.03125; R2 and R4 use 0.125; R3 uses 0.25; R0 and R6 use 0.
- Stage 2 (add and finish):
  - s = intercept + (p >>> FRAC_WIDTH), arithmetic shift, i.e. floor.
  - Intercepts: R0 = 0, R1 = 0.15625, R2 = 0.375, R3 = 0.5, R4 = 0.625, R5 = 0.84375, R6 = 1.0.
  - Sigmoid: y = s. Tanh: y = 2s − 1.0.
  - The result is computed at WIDTH+2 bits and saturated to WIDTH bits. Saturation is a no-op for legal s ∈ [0, 1.0].
- Lanes are independent and identical. All lanes share the stage valid and mode.
- busy = OR of the stage-0, stage-1 and stage-2 valid bits.

## Timing
- Latency: 3 cycles from an accepted input (in_valid && in_ready at edge N) to out_valid at edge N+3, when unstalled.
- Throughput: 1 transaction per cycle.
- Stall rule: stall = out_valid && !out_ready.
  - While stalled, all stage registers hold.
  - in_ready = !stall && !reset.
  - Bubbles are not collapsed. A full-pipeline stall is acceptable.
- Once out_valid is asserted, out_y and out_mode stay stable until the output is accepted.
- When in_valid is low while not stalled, a bubble (valid = 0) enters stage 0.
- Reset, with the edge sampled high:
  - All stage valid bits clear.
  - out_valid = 0, out_y = 0, out_mode = 0, busy = 0.
  - In-flight data is discarded.
  - in_ready is 0 while reset is high.
- Reset asserted mid-stall drops the held output; nothing reappears after reset.
- Simultaneous output accept and input accept in the same cycle are both legal and both take effect.

## Test plan
Values below use defaults (FRAC_WIDTH = 8, WIDTH = 17, raw integers).
- Sigmoid, lanes {0, 256, −256, 384} → out_y {128, 192, 64, 208}, 3 cycles after accept.
- Sigmoid boundaries and floor, lanes {−1280, −1, 1281, −65536} → {0, 127, 256, 0}. −1 checks floor rounding; 1281 falls in R6.
- Tanh, lanes {0, 128, −128, 51200} → {0, 128, −128, 256}. 51200 exercises 2x saturation to 65535, then R6.
- Back-to-back stream of 20 transactions with alternating mode, out_ready held at 1 → one output per cycle, in order, each out_mode matching its input.
- Backpressure: drop out_ready for 5 cycles mid-stream → in_ready goes low; out_y is held stable; no transaction is lost or duplicated; order is preserved after release.
- Assert reset for 1 cycle while the pipeline is full and stalled → next cycle out_valid = 0, busy = 0, out_y = 0; the first new input appears after exactly 3 cycles.

Source files
------------

// File: rtl/pwl_activation.sv
// -----------------------------------------------------------------------------
// pwl_activation
//
// Pipelined, multi-lane piecewise-linear sigmoid / tanh unit.
//
// Both functions share one 7-region sigmoid approximation. Tanh is formed as
// 2*sigma(2x) - 1. Three register stages: argument prep, multiply, then
// add/finish. A single stall signal freezes every stage while the output is
// offered but not taken.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   input transaction valid
//   in_ready   unit can accept input this cycle
//   in_mode    0 = sigmoid, 1 = tanh
//   in_x       LANES packed signed operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid  output transaction valid
//   out_ready  downstream accepts output
//   out_mode   mode carried with the transaction
//   out_y      LANES packed signed results, same Q format as in_x
//   busy       any stage holds a valid transaction
// -----------------------------------------------------------------------------
module pwl_activation #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
    parameter int LANES      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [LANES*WIDTH-1:0]   in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_mode,
    output logic [LANES*WIDTH-1:0]   out_y,
    output logic                     busy
);

    typedef enum logic [2:0] {R0, R1, R2, R3, R4, R5, R6} region_e;

    // Fixed-point constants, truncated toward zero (all are positive).
    localparam longint ONE_L = 64'sd1 <<< FRAC_WIDTH;

    localparam logic signed [WIDTH-1:0] TH_5    = WIDTH'(5 * ONE_L);
    localparam logic signed [WIDTH-1:0] TH_2375 = WIDTH'((19 * ONE_L) / 8);
    localparam logic signed [WIDTH-1:0] TH_1    = WIDTH'(ONE_L);

    localparam logic signed [WIDTH-1:0] SL_OUTER = WIDTH'(ONE_L / 32);
    localparam logic signed [WIDTH-1:0] SL_MID   = WIDTH'(ONE_L / 8);
    localparam logic signed [WIDTH-1:0] SL_INNER = WIDTH'(ONE_L / 4);

    localparam logic signed [WIDTH+1:0] IC_R1 = (WIDTH+2)'((5 * ONE_L) / 32);
    localparam logic signed [WIDTH+1:0] IC_R2 = (WIDTH+2)'((3 * ONE_L) / 8);
    localparam logic signed [WIDTH+1:0] IC_R3 = (WIDTH+2)'(ONE_L / 2);
    localparam logic signed [WIDTH+1:0] IC_R4 = (WIDTH+2)'((5 * ONE_L) / 8);
    localparam logic signed [WIDTH+1:0] IC_R5 = (WIDTH+2)'((27 * ONE_L) / 32);
    localparam logic signed [WIDTH+1:0] IC_R6 = (WIDTH+2)'(ONE_L);

    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH+1:0] Y_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] Y_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    // Shared per-stage control.
    logic v0_q, v1_q, v2_q;
    logic m0_q, m1_q, m2_q;
    logic stall;

    assign stall     = v2_q && !out_ready;
    assign in_ready  = !stall && !reset;
    assign out_valid = v2_q;
    assign out_mode  = m2_q;
    assign busy      = v0_q || v1_q || v2_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's value from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            m0_q <= 1'b0;
            m1_q <= 1'b0;
            m2_q <= 1'b0;
        end else if (!stall) begin
            v0_q <= in_valid;
            m0_q <= in_mode;
            v1_q <= v0_q;
            m1_q <= m0_q;
            v2_q <= v1_q;
            if (v1_q) begin
                m2_q <= m1_q;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [WIDTH-1:0]   x;
        logic signed [WIDTH:0]     x2;
        logic signed [WIDTH-1:0]   u_d, u_q;
        region_e                   rg_d, rg0_q, rg1_q;
        logic signed [WIDTH-1:0]   slope;
        logic signed [2*WIDTH-1:0] u_ext, sl_ext, p_d, p_q, p_sh;
        logic signed [WIDTH+1:0]   icpt, s, y_wide;
        logic signed [WIDTH-1:0]   y_d, y_q;
        logic                      unused_p;

        assign x  = in_x[g*WIDTH +: WIDTH];
        assign x2 = {x, 1'b0};

        // Stage 0: argument prep and region select.
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            u_d = x;
            if (in_mode) begin
                // Doubling overflowed when the two top bits disagree.
                if (x2[WIDTH] != x2[WIDTH-1]) begin
                    u_d = x2[WIDTH] ? S_MIN : S_MAX;
                end else begin
                    u_d = x2[WIDTH-1:0];
                end
            end
            rg_d = R6;
            if      (u_d <= -TH_5)    rg_d = R0;
            else if (u_d <= -TH_2375) rg_d = R1;
            else if (u_d <= -TH_1)    rg_d = R2;
            else if (u_d <= TH_1)     rg_d = R3;
            else if (u_d <= TH_2375)  rg_d = R4;
            else if (u_d <= TH_5)     rg_d = R5;
        end

        // Stage 1: multiply by the region slope at full double width.
        always_comb begin
            slope = '0;
            case (rg0_q)
                R1, R5:  slope = SL_OUTER;
                R2, R4:  slope = SL_MID;
                R3:      slope = SL_INNER;
                default: slope = '0;
            endcase
        end

        assign u_ext  = {{WIDTH{u_q[WIDTH-1]}}, u_q};
        assign sl_ext = {{WIDTH{slope[WIDTH-1]}}, slope};
        assign p_d    = u_ext * sl_ext;

        // Stage 2: floor-shift, add intercept, optional tanh remap, saturate.
        always_comb begin
            icpt = '0;
            case (rg1_q)
                R1:      icpt = IC_R1;
                R2:      icpt = IC_R2;
                R3:      icpt = IC_R3;
                R4:      icpt = IC_R4;
                R5:      icpt = IC_R5;
                R6:      icpt = IC_R6;
                default: icpt = '0;
            endcase
        end

        assign p_sh     = p_q >>> FRAC_WIDTH;
        assign unused_p = ^p_sh[2*WIDTH-1:WIDTH+2];
        assign s        = p_sh[WIDTH+1:0] + icpt;

        always_comb begin
            y_wide = s;
            if (m1_q) begin
                y_wide = {s[WIDTH:0], 1'b0} - IC_R6;
            end
            y_d = y_wide[WIDTH-1:0];
            if (y_wide > Y_MAX) begin
                y_d = S_MAX;
            end else if (y_wide < Y_MIN) begin
                y_d = S_MIN;
            end
        end

        // NOTE: the datapath registers carry no reset; the valid bits alone
        // decide whether their contents mean anything.
        always_ff @(posedge clk) begin
            if (!stall) begin
                u_q   <= u_d;
                rg0_q <= rg_d;
                p_q   <= p_d;
                rg1_q <= rg0_q;
            end
        end

        // The visible result is cleared on reset and only loads real data,
        // so out_y stays zero until the first transaction arrives.
        always_ff @(posedge clk) begin
            if (reset) begin
                y_q <= '0;
            end else if (!stall && v1_q) begin
                y_q <= y_d;
            end
        end

        assign out_y[g*WIDTH +: WIDTH] = y_q;
    end

endmodule
